// File: rtl/clk_div_game_multi.sv
// Multi-channel programmable timebase generator for the game logic.
// Each channel has its own divisor, enable and mode: toggle clock,
// tick pulse or one-shot timer. All outputs are registered.
module clk_div_game_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 62500000,
   parameter int unsigned SEL_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     en,
   input  logic [2*NUM_CH-1:0]   mode,
   input  logic [NUM_CH-1:0]     start,
   input  logic                  sync_clr,
   input  logic                  div_we,
   input  logic [SEL_W-1:0]      div_sel,
   input  logic [CNT_W-1:0]      div_wdata,
   output logic [NUM_CH-1:0]     clk_div,
   output logic [NUM_CH-1:0]     tick,
   output logic [NUM_CH-1:0]     busy,
   output logic                  div_err
);

   typedef enum logic [1:0] {
      MODE_TOGGLE    = 2'b00,
      MODE_PULSE     = 2'b01,
      MODE_ONESHOT   = 2'b10,
      MODE_PULSE_ALT = 2'b11
   } mode_t;

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] count [NUM_CH];
   logic [CNT_W-1:0] div   [NUM_CH];
   mode_t            ch_mode [NUM_CH];
   logic             sel_ok;
   logic             wr_accept;
   logic             wr_reject;

   // Decode per-channel mode fields and qualify divisor writes
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_mode[i] = mode_t'(mode[2*i +: 2]);
      end
      sel_ok    = (32'(div_sel) < NUM_CH);
      wr_accept = div_we && sel_ok && (div_wdata != '0);
      wr_reject = div_we && !(sel_ok && (div_wdata != '0));
   end

   // Per-channel counters, divisors and registered outputs
   always_ff @(posedge clk) begin
      if (!rst || sync_clr) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            count[i] <= '0;
            div[i]   <= DIV_RST;
         end
         clk_div <= '0;
         tick    <= '0;
         busy    <= '0;
         div_err <= 1'b0;
      end else begin
         div_err <= wr_reject;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_accept && (32'(div_sel) == i)) begin
               // Accepted write restarts this channel; clk_div and busy hold
               div[i]   <= div_wdata;
               count[i] <= '0;
               tick[i]  <= 1'b0;
            end else begin
               if (ch_mode[i] != MODE_TOGGLE) begin
                  clk_div[i] <= 1'b0;
               end
               if (ch_mode[i] == MODE_ONESHOT && start[i]) begin
                  count[i] <= '0;
                  busy[i]  <= 1'b1;
                  tick[i]  <= 1'b0;
               end else if (!en[i] || (ch_mode[i] == MODE_ONESHOT && !busy[i])) begin
                  tick[i] <= 1'b0;
               end else if (count[i] == div[i] - CNT_W'(1)) begin
                  count[i] <= '0;
                  tick[i]  <= 1'b1;
                  if (ch_mode[i] == MODE_TOGGLE) begin
                     clk_div[i] <= ~clk_div[i];
                  end
                  if (ch_mode[i] == MODE_ONESHOT) begin
                     busy[i] <= 1'b0;
                  end
               end else begin
                  count[i] <= count[i] + CNT_W'(1);
                  tick[i]  <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_game_multi.sv
// Directed testbench for clk_div_game_multi: two channels, DEFAULT_DIV=5.
// Expected outputs per cycle are hand-derived as functions of the edge number.
module tb_clk_div_game_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  en;
   logic [3:0]  mode;
   logic [1:0]  start;
   logic        sync_clr;
   logic        div_we;
   logic [1:0]  div_sel;
   logic [31:0] div_wdata;
   logic [1:0]  clk_div;
   logic [1:0]  tick;
   logic [1:0]  busy;
   logic        div_err;

   int checks = 0;
   int errors = 0;

   clk_div_game_multi #(
      .NUM_CH(2),
      .CNT_W(32),
      .DEFAULT_DIV(5),
      .SEL_W(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .start(start),
      .sync_clr(sync_clr),
      .div_we(div_we),
      .div_sel(div_sel),
      .div_wdata(div_wdata),
      .clk_div(clk_div),
      .tick(tick),
      .busy(busy),
      .div_err(div_err)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   // Channel 0 divided clock level after edge n
   function automatic logic e_clk0(int n);
      int m;
      if (n >= 125) return (n <= 130) ? logic'((n - 125) % 2) : 1'b0;
      if (n >= 113) return logic'(((n - 113) / 5) % 2);
      if (n >= 99)  return logic'(((n - 99) / 5) % 2);
      if (n >= 60 && n <= 66) return 1'b1;
      m = (n >= 67) ? n - 7 : n;
      if (m < 28) return logic'((m / 5) % 2);
      return (((m - 28) / 3) % 2) == 0;
   endfunction

   function automatic logic e_tick0(int n);
      int m;
      int k;
      if (n >= 125) return n >= 126;
      if (n >= 113) begin
         k = n - 113;
         return (k > 0) && (k % 5 == 0);
      end
      if (n >= 99) begin
         k = n - 99;
         return (k > 0) && (k % 5 == 0);
      end
      if (n >= 60 && n <= 66) return 1'b0;
      m = (n >= 67) ? n - 7 : n;
      if (m < 28) return (m % 5) == 0;
      return (m > 28) && ((m - 28) % 3 == 0);
   endfunction

   function automatic logic e_tick1(int n);
      if (n <= 75) return (n % 5) == 0;
      if (n < 99)  return (n == 83) || (n == 94);
      return n == 119;
   endfunction

   function automatic logic e_busy1(int n);
      return (n >= 79 && n <= 82) || (n >= 87 && n <= 93) ||
             (n == 112) || (n >= 114 && n <= 118);
   endfunction

   initial begin
      rst       = 1'b0;
      en        = 2'b00;
      mode      = 4'b0100;
      start     = 2'b00;
      sync_clr  = 1'b0;
      div_we    = 1'b0;
      div_sel   = 2'd0;
      div_wdata = 32'd0;

      repeat (3) step();
      chk("rst_clk_div", 0, 32'(clk_div), 32'd0);
      chk("rst_tick",    0, 32'(tick),    32'd0);
      chk("rst_busy",    0, 32'(busy),    32'd0);
      chk("rst_div_err", 0, 32'(div_err), 32'd0);

      rst = 1'b1;
      en  = 2'b11;

      for (int n = 1; n <= 133; n++) begin
         step();
         chk("clk_div", n, 32'(clk_div), 32'({1'b0, e_clk0(n)}));
         chk("tick",    n, 32'(tick),    32'({e_tick1(n), e_tick0(n)}));
         chk("busy",    n, 32'(busy),    32'({e_busy1(n), 1'b0}));
         chk("div_err", n, 32'(div_err), 32'((n == 46) || (n == 47)));
         case (n)
            27:  begin div_we = 1'b1; div_sel = 2'd0; div_wdata = 32'd3; end
            28:  div_we = 1'b0;
            45:  begin div_we = 1'b1; div_sel = 2'd0; div_wdata = 32'd0; end
            46:  begin div_sel = 2'd3; div_wdata = 32'd7; end
            47:  div_we = 1'b0;
            59:  en = 2'b10;
            66:  en = 2'b11;
            75:  begin div_we = 1'b1; div_sel = 2'd1; div_wdata = 32'd4; mode = 4'b1000; end
            76:  div_we = 1'b0;
            78:  start = 2'b10;
            79:  start = 2'b00;
            86:  start = 2'b10;
            87:  start = 2'b00;
            89:  start = 2'b10;
            90:  start = 2'b00;
            98:  begin sync_clr = 1'b1; div_we = 1'b1; div_sel = 2'd0; div_wdata = 32'd9; end
            99:  begin sync_clr = 1'b0; div_we = 1'b0; end
            110: begin div_we = 1'b1; div_sel = 2'd1; div_wdata = 32'd2; end
            111: begin div_we = 1'b0; start = 2'b10; end
            112: begin start = 2'b00; rst = 1'b0; end
            113: begin rst = 1'b1; start = 2'b10; end
            114: start = 2'b00;
            124: begin div_we = 1'b1; div_sel = 2'd0; div_wdata = 32'd1; end
            125: div_we = 1'b0;
            130: mode = 4'b1001;
            default: ;
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
